// File: rtl/jzjpcc_pkg.sv
// Shared definitions for the jzjpcc pipeline stages.
package jzjpcc_pkg;

  // addi x0,x0,0 with the implied 2'b11 low bits dropped.
  // Decode and control logic also use this constant when they squash an instruction.
  localparam logic [31:2] NOP_INSTRUCTION = 30'h00000004;

  // Number of bits in a word-granular PC whose MSB index is pc_max_b.
  function automatic int pc_word_bits(input int pc_max_b);
    return pc_max_b - 1;
  endfunction

endpackage

// File: rtl/jzjpcc_pc.sv
// Program counter: selects the next PC (redirect, hold or increment)
// and returns to RESET_PC on reset.
module jzjpcc_pc
  import jzjpcc_pkg::*;
#(
  parameter int                PC_MAX_B = 15,
  parameter logic [PC_MAX_B:2] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                redirect,
  input  logic [PC_MAX_B:2]   redirect_pc,
  input  logic                hold,
  output logic [PC_MAX_B:2]   pc
);

  localparam int PC_W = pc_word_bits(PC_MAX_B);
  typedef logic [PC_W+1:2] pc_t;
  localparam pc_t PC_ONE = pc_t'(1);

  pc_t pc_next;

  // Next-PC mux: a redirect comes from an older instruction, so it beats a stall.
  // The increment wraps silently at the top of the instruction space.
  always_comb begin
    pc_next = pc + PC_ONE;
    if (redirect) begin
      pc_next = redirect_pc;
    end else if (hold) begin
      pc_next = pc;
    end
  end

  // PC register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/jzjpcc_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and
// loads the fetch/decode register, squashing to NOP on redirect or flush.
module jzjpcc_fetch
  import jzjpcc_pkg::*;
#(
  parameter int                PC_MAX_B = 15,
  parameter logic [PC_MAX_B:2] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  output logic [PC_MAX_B:2]   instructionAddress_fetch,
  input  logic [31:2]         instruction_fetch,
  output logic [31:2]         instruction_decode,
  output logic [PC_MAX_B:2]   currentPC_decode,
  input  logic                pcCTWriteEnable,
  input  logic [PC_MAX_B:2]   controlTransferNewPC,
  input  logic                stall_fetch,
  input  logic                flush_decode
);

  localparam int PC_W = pc_word_bits(PC_MAX_B);
  typedef logic [PC_W+1:2] pc_t;

  pc_t pc;

  jzjpcc_pc #(
    .PC_MAX_B (PC_MAX_B),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock       (clock),
    .reset       (reset),
    .redirect    (pcCTWriteEnable),
    .redirect_pc (controlTransferNewPC),
    .hold        (stall_fetch),
    .pc          (pc)
  );

  // The memory address is the PC itself. Nothing else sits on this path.
  assign instructionAddress_fetch = pc;

  // Fetch/decode register. On a redirect the word fetched this cycle is wrong-path.
  // A stall freezes the register, but a flush still squashes the instruction.
  // The memory data is only selected on the plain-advance path, so undefined
  // data during a squash cannot reach decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instruction_decode <= NOP_INSTRUCTION;
      currentPC_decode   <= '0;
    end else if (pcCTWriteEnable) begin
      instruction_decode <= NOP_INSTRUCTION;
      currentPC_decode   <= pc;
    end else if (stall_fetch) begin
      if (flush_decode) begin
        instruction_decode <= NOP_INSTRUCTION;
      end
    end else if (flush_decode) begin
      instruction_decode <= NOP_INSTRUCTION;
      currentPC_decode   <= pc;
    end else begin
      instruction_decode <= instruction_fetch;
      currentPC_decode   <= pc;
    end
  end

endmodule

// File: tb/tb_jzjpcc_fetch.sv
// Self-checking bench for jzjpcc_fetch: directed scenarios followed by
// randomized control traffic checked against a behavioural fetch model.
module tb_jzjpcc_fetch;

  localparam logic [29:0] NOP = 30'h00000004;
  localparam int unsigned PC_SPACE = 16384;

  logic        clock;
  logic        reset;
  logic [15:2] instructionAddress_fetch;
  logic [31:2] instruction_fetch;
  logic [31:2] instruction_decode;
  logic [15:2] currentPC_decode;
  logic        pcCTWriteEnable;
  logic [15:2] controlTransferNewPC;
  logic        stall_fetch;
  logic        flush_decode;
  logic        poison;

  // Second build with a nonzero reset vector shares the control inputs.
  logic [15:2] addr_b;
  logic [31:2] ifetch_b;
  logic [31:2] idec_b;
  logic [15:2] cpc_b;

  int passed = 0;
  int total  = 0;

  // Reference model state.
  int unsigned m_pc;
  int unsigned m_cpc;
  logic [29:0] m_ins;

  function automatic logic [29:0] mem(input int unsigned a);
    logic [13:0] a14;
    a14 = a[13:0];
    return {16'hA5A5, a14};
  endfunction

  assign instruction_fetch = poison ? 30'h3FFFFFFF : mem(32'(instructionAddress_fetch));
  assign ifetch_b          = mem(32'(addr_b));

  jzjpcc_fetch dut (
    .clock                    (clock),
    .reset                    (reset),
    .instructionAddress_fetch (instructionAddress_fetch),
    .instruction_fetch        (instruction_fetch),
    .instruction_decode       (instruction_decode),
    .currentPC_decode         (currentPC_decode),
    .pcCTWriteEnable          (pcCTWriteEnable),
    .controlTransferNewPC     (controlTransferNewPC),
    .stall_fetch              (stall_fetch),
    .flush_decode             (flush_decode)
  );

  jzjpcc_fetch #(.PC_MAX_B(15), .RESET_PC(14'h0040)) dut_b (
    .clock                    (clock),
    .reset                    (reset),
    .instructionAddress_fetch (addr_b),
    .instruction_fetch        (ifetch_b),
    .instruction_decode       (idec_b),
    .currentPC_decode         (cpc_b),
    .pcCTWriteEnable          (pcCTWriteEnable),
    .controlTransferNewPC     (controlTransferNewPC),
    .stall_fetch              (stall_fetch),
    .flush_decode             (flush_decode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_addr"}, 32'(instructionAddress_fetch), m_pc);
    check({tag, "_ins"},  32'(instruction_decode),       32'(m_ins));
    check({tag, "_cpc"},  32'(currentPC_decode),         m_cpc);
  endtask

  // Apply one posedge with the inputs currently driven and advance the model.
  task automatic step(input string tag);
    int unsigned npc;
    int unsigned ncpc;
    logic [29:0] nins;
    if (pcCTWriteEnable) begin
      npc  = 32'(controlTransferNewPC);
      nins = NOP;
      ncpc = m_pc;
    end else if (stall_fetch) begin
      npc  = m_pc;
      nins = flush_decode ? NOP : m_ins;
      ncpc = m_cpc;
    end else begin
      npc  = (m_pc + 1) % PC_SPACE;
      nins = flush_decode ? NOP : mem(m_pc);
      ncpc = m_pc;
    end
    @(posedge clock);
    #1;
    m_pc  = npc;
    m_ins = nins;
    m_cpc = ncpc;
    check_model(tag);
  endtask

  task automatic set_in(input logic ct, input logic [15:2] tgt, input logic st, input logic fl);
    pcCTWriteEnable      = ct;
    controlTransferNewPC = tgt;
    stall_fetch          = st;
    flush_decode         = fl;
    poison               = ct | fl;
  endtask

  // Assert reset away from any clock edge, check it took effect at once, then release.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    m_pc  = 0;
    m_ins = NOP;
    m_cpc = 0;
    check_model(tag);
    check({tag, "_b_addr"}, 32'(addr_b), 32'h40);
    check({tag, "_b_ins"},  32'(idec_b), 32'(NOP));
    check({tag, "_b_cpc"},  32'(cpc_b),  32'h0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    set_in(1'b0, 14'h0, 1'b0, 1'b0);
    #2;
    apply_reset("rst0");

    // Sequential fetch from the reset vector.
    for (int k = 1; k <= 3; k++) begin
      step("seq");
      check("seq_ins_const", 32'(instruction_decode), 32'(mem(k - 1)));
      check("seq_cpc_const", 32'(currentPC_decode),   k - 1);
    end
    step("seq");
    step("seq");

    // Redirect at PC=5.
    check("pre_redir_pc", 32'(instructionAddress_fetch), 32'h5);
    set_in(1'b1, 14'h0100, 1'b0, 1'b0);
    step("redir");
    check("redir_pc",  32'(instructionAddress_fetch), 32'h100);
    check("redir_ins", 32'(instruction_decode),       32'(NOP));
    check("redir_cpc", 32'(currentPC_decode),         32'h5);
    set_in(1'b0, 14'h0, 1'b0, 1'b0);
    step("post_redir");
    check("post_redir_ins", 32'(instruction_decode), 32'(mem(32'h100)));
    check("post_redir_cpc", 32'(currentPC_decode),   32'h100);

    // Mid-run reset with PC=0x123 and no clock edge in between.
    set_in(1'b1, 14'h0123, 1'b0, 1'b0);
    step("to123");
    set_in(1'b0, 14'h0, 1'b0, 1'b0);
    check("pc_123", 32'(instructionAddress_fetch), 32'h123);
    apply_reset("rst_mid");

    // Advance to PC=7, then stall for two cycles.
    for (int k = 0; k < 7; k++) step("to7");
    set_in(1'b0, 14'h0, 1'b1, 1'b0);
    step("stall1");
    step("stall2");
    check("stall_pc",  32'(instructionAddress_fetch), 32'h7);
    check("stall_ins", 32'(instruction_decode),       32'(mem(6)));
    check("stall_cpc", 32'(currentPC_decode),         32'h6);
    set_in(1'b0, 14'h0, 1'b1, 1'b1);
    step("stall_flush");
    check("sf_ins", 32'(instruction_decode),       32'(NOP));
    check("sf_pc",  32'(instructionAddress_fetch), 32'h7);
    check("sf_cpc", 32'(currentPC_decode),         32'h6);

    // Redirect beats stall and flush.
    set_in(1'b1, 14'h0020, 1'b1, 1'b1);
    step("all3");
    check("all3_pc",  32'(instructionAddress_fetch), 32'h20);
    check("all3_ins", 32'(instruction_decode),       32'(NOP));
    check("all3_cpc", 32'(currentPC_decode),         32'h7);

    // Plain flush advances the PC.
    set_in(1'b0, 14'h0, 1'b0, 1'b1);
    step("flush");
    check("flush_pc", 32'(instructionAddress_fetch), 32'h21);

    // Wrap at the top of the instruction space.
    set_in(1'b1, 14'h3FFF, 1'b0, 1'b0);
    step("to3fff");
    set_in(1'b0, 14'h0, 1'b0, 1'b0);
    step("wrap");
    check("wrap_pc",  32'(instructionAddress_fetch), 32'h0);
    check("wrap_cpc", 32'(currentPC_decode),         32'h3FFF);
    check("wrap_ins", 32'(instruction_decode),       32'(mem(32'h3FFF)));

    // Randomized control traffic; memory data is corrupted whenever it must be discarded.
    for (int n = 0; n < 400; n++) begin
      pcCTWriteEnable      = ($urandom_range(0, 9) == 0);
      controlTransferNewPC = 14'($urandom);
      stall_fetch          = ($urandom_range(0, 5) == 0);
      flush_decode         = ($urandom_range(0, 6) == 0);
      poison               = (pcCTWriteEnable | flush_decode | stall_fetch) & ($urandom_range(0, 1) == 1);
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jzjpcc_fetch.md
Name: jzjpcc_fetch

Overview:
Fetch stage of the jzjpcc pipelined RV32I core; produces the fetch-to-decode pipeline register that jzjpcc_decode consumes (instruction_decode, currentPC_decode).
Owns the program counter and drives the instruction memory read address.
Applies control-transfer redirects (pcCTWriteEnable / controlTransferNewPC) from later stages.
Applies hazard stalls and flushes to the decode register.

Parameters:
PC_MAX_B, 15, MSB index of PC; PC is word address [PC_MAX_B:2] (default 14 bits, 64 KiB instruction space)
RESET_PC, 0, word address [PC_MAX_B:2] loaded into PC on reset

Ports:
clock  input  1  core clock, all state on posedge
reset  input  1  asynchronous, active-high reset
instructionAddress_fetch  output  [PC_MAX_B:2]  instruction memory read address (= PC register)
instruction_fetch  input  [31:2]  instruction memory read data, combinational from instructionAddress_fetch
instruction_decode  output  [31:2]  fetch/decode register: instruction word (bits 1:0 implied 2'b11)
currentPC_decode  output  [PC_MAX_B:2]  fetch/decode register: PC of instruction_decode
pcCTWriteEnable  input  1  control transfer: load controlTransferNewPC instead of PC+1
controlTransferNewPC  input  [PC_MAX_B:2]  redirect target, word address
stall_fetch  input  1  hold PC and fetch/decode register (load-use hazard)
flush_decode  input  1  replace next fetch/decode contents with NOP

Behaviour:
- NOP = addi x0,x0,0 = 32'h00000013; [31:2] encoding = 30'h00000004.
- Reset (async, immediate, independent of clock):
  - PC = RESET_PC
  - instruction_decode = NOP
  - currentPC_decode = 0
- Reset deassertion: first posedge after release latches instruction_fetch at RESET_PC.
- instructionAddress_fetch = PC, combinational; no other logic in the path.
- Latency: instruction at PC appears on instruction_decode one posedge after PC holds it.
- Per posedge (reset low), priority top-down:
  1. pcCTWriteEnable=1:
     - PC <= controlTransferNewPC
     - instruction_decode <= NOP (wrong-path fetch squashed)
     - currentPC_decode <= PC
     - Overrides stall_fetch and flush_decode: the redirect comes from an older instruction.
  2. else stall_fetch=1:
     - PC and the fetch/decode register hold.
     - If flush_decode is also 1: instruction_decode <= NOP and currentPC_decode holds; PC still holds.
  3. else flush_decode=1:
     - PC <= PC+1
     - instruction_decode <= NOP
     - currentPC_decode <= PC
  4. else:
     - PC <= PC+1
     - instruction_decode <= instruction_fetch
     - currentPC_decode <= PC
- PC+1 is word-granular, modulo 2^(PC_MAX_B-1); all-ones wraps to 0 with no flag.
- controlTransferNewPC is taken unmodified; no alignment check (word address by construction).
- Inputs sampled only at posedge; X on instruction_fetch while flushing or redirecting must not reach instruction_decode.
- No internal state beyond the PC and the fetch/decode register; no FSM beyond these priority rules.

Decomposition:
- Shared package jzjpcc_pkg:
  - localparam NOP_INSTRUCTION [31:2] = 30'h4, reused by decode/control flush logic
  - typedef for pc word address width helper (function or parameterised typedef)
- Sub-module jzjpcc_pc: PC register, next-PC mux (redirect / hold / increment), reset-to-RESET_PC.
- jzjpcc_fetch instantiates jzjpcc_pc and holds the fetch/decode register with the NOP/stall muxing.

Test Plan:
- Reset asserted mid-run while PC=14'h0123, no clock edge → same-time instructionAddress_fetch=0, instruction_decode=30'h4, currentPC_decode=0; RESET_PC=14'h0040 build → address 14'h0040.
- Sequential fetch, memory model returns {16'hA5A5, addr} → after edges 1..3 instruction_decode tracks addresses 0,1,2; currentPC_decode = 0,1,2; instructionAddress_fetch one ahead.
- Redirect at PC=5, controlTransferNewPC=14'h0100 → next edge: PC=0x100, instruction_decode=30'h4, currentPC_decode=5; following edge: instruction_decode = mem[0x100], currentPC_decode=0x100.
- stall_fetch high 2 cycles at PC=7 → PC stays 7, instruction_decode/currentPC_decode frozen at word 6; stall+flush_decode on one edge → instruction_decode=30'h4, PC=7.
- stall_fetch=1, flush_decode=1, pcCTWriteEnable=1 same edge, target 14'h0020 → PC=0x20, instruction_decode=NOP (redirect wins).
- PC=14'h3FFF, no stall/redirect → next PC=14'h0000, currentPC_decode=14'h3FFF.
